multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge system clock.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-003 SHALL have port: opcode  input  4  IR[15:12] of latched instruction.
REQ-004 SHALL have port: ir_cz  input  2  IR[1:0] condition field (passed to register file, used for ADC/ADZ).
REQ-005 SHALL have port: alu_zero  input  1  ALU equality result, valid in BRANCH state.
REQ-006 SHALL have port: mem_ready  input  1  memory completes current access this cycle.
REQ-007 SHALL have ports: pc_we, ir_we, mem_re, mem_we, rf_we  output  1 each  register and memory enables.
REQ-008 SHALL have port: alu_f  output  3  ALU function (000 ADD, 001 NAND, 010 PASS_B, 011 SUB, 100 ADDR_ADD).
REQ-009 SHALL have ports: srca_sel  output  2; srcb_sel  output  2; wa_sel  output  2; wd_sel  output  2; pc_sel  output  2  datapath mux selects.
REQ-010 SHALL have ports: state  output  4  current FSM state; illegal  output  1  one-cycle pulse on undefined opcode.

Function
REQ-011 SHALL implement states FETCH, DECODE, EXEC, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, JUMP.
REQ-012 FETCH: mem_re=1. Stays in FETCH while mem_ready=0. When mem_ready=1: ir_we=1, pc_we=1 (pc_sel=PC+1), then DECODE.
REQ-013 DECODE: takes 1 cycle, reads operands, then branches on opcode: 0000/0001/0010/0011 go to EXEC; 0100/0101 go to MEMADR; 1100 goes to BRANCH; 1000/1001 go to JUMP. Any other opcode pulses illegal and returns to FETCH.
REQ-014 EXEC: alu_f per opcode (0000 and 0001 use 000, 0010 uses 001, 0011 uses 010), then ALUWB.
REQ-015 ALUWB: rf_we=1 for exactly 1 cycle, with alu_f held at the EXEC value so the register file updates C/Z, then FETCH; the register file suppresses the write for ADC/ADZ.
REQ-016 MEMADR: alu_f=100; goes to MEMRD for 0100 and to MEMWR for 0101.
REQ-017 MEMRD: mem_re=1 and waits for mem_ready, then MEMWB. MEMWB: rf_we=1, wd_sel=MEM, alu_f=100, then FETCH.
REQ-018 MEMWR: mem_we=1 and waits for mem_ready, then FETCH; rf_we=0.
REQ-019 BRANCH: alu_f=011 with rf_we=0. If alu_zero=1: pc_we=1, pc_sel=PC+imm. Then FETCH.
REQ-020 JUMP: rf_we=1, wd_sel=PC, pc_we=1. pc_sel is PC+imm for 1000 and RB for 1001. Then FETCH.
REQ-021 In every state other than EXEC, ALUWB and BRANCH, alu_f SHALL be 100 so flags never change spuriously.
REQ-022 Enables SHALL be Moore outputs decoded from state, except ir_we/pc_we in FETCH and pc_we in BRANCH, which are qualified by inputs.
REQ-023 mem_re and mem_we SHALL never be asserted together; rf_we SHALL never be asserted in FETCH, DECODE, MEMADR, MEMRD, MEMWR or BRANCH.
REQ-024 Worst-case latency with zero wait states: ALU instr 4 cycles, LW 5, SW 4, BEQ 3, JAL/JLR 3.

Reset
REQ-025 reset=1 at a clk edge SHALL force state to FETCH, including mid-instruction or mid-wait.
REQ-026 While reset is high, all enables and illegal SHALL be 0, alu_f=100, and all selects 00.
REQ-027 The first FETCH after reset deassertion SHALL assert mem_re in the same cycle.

Structure
REQ-028 Package risc_ctrl_pkg SHALL hold the state enum, opcode constants, alu_f codes and mux-select encodings, shared with the datapath.
REQ-029 The block SHALL contain one sub-module, ctrl_decode: combinational opcode to instruction class and EXEC alu_f.
REQ-030 The block SHALL use a single state register; outputs SHALL be combinational from state and inputs only.

Verification
REQ-031 Bench SHALL cover: reset, then ADD (0000) with mem_ready=1 -> states FETCH, DECODE, EXEC, ALUWB; rf_we high 1 cycle with alu_f=000; back in FETCH at cycle 5.
REQ-032 Bench SHALL cover: LW with mem_ready low for 3 cycles in MEMRD -> mem_re held 4 cycles, rf_we only in MEMWB with alu_f=100.
REQ-033 Bench SHALL cover: BEQ with alu_zero=0, then BEQ with alu_zero=1 -> pc_we=0, then pc_we=1 with pc_sel=PC+imm; rf_we=0 in both.
REQ-034 Bench SHALL cover: opcode 1111 -> illegal pulse 1 cycle in DECODE, next state FETCH, no writes.
REQ-035 Bench SHALL cover: reset asserted during MEMWR wait -> next cycle state=FETCH, mem_we=0.
REQ-036 Bench SHALL check continuously: mem_re and mem_we are never high together, and alu_f<011 occurs only with state in {EXEC, ALUWB}.

Source files
------------

// File: rtl/risc_ctrl_pkg.sv
// Shared encodings for the multicycle RISC controller and its datapath:
// FSM states, opcodes, ALU function codes and mux-select values.
package risc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_ALUWB  = 4'd3,
    S_MEMADR = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWB  = 4'd6,
    S_MEMWR  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_JAL     = 3'd4,
    CLS_JLR     = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_cls_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_NAND  = 3'b001;
  localparam logic [2:0] ALU_PASSB = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_ADDR  = 3'b100;

  localparam logic [1:0] SRCA_RA   = 2'b00;
  localparam logic [1:0] SRCA_RB   = 2'b01;

  localparam logic [1:0] SRCB_RB   = 2'b00;
  localparam logic [1:0] SRCB_IMM6 = 2'b01;
  localparam logic [1:0] SRCB_IMM9 = 2'b10;

  localparam logic [1:0] WA_RC     = 2'b00;
  localparam logic [1:0] WA_RB     = 2'b01;
  localparam logic [1:0] WA_RA     = 2'b10;

  localparam logic [1:0] WD_ALU    = 2'b00;
  localparam logic [1:0] WD_MEM    = 2'b01;
  localparam logic [1:0] WD_PC     = 2'b10;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_IMM    = 2'b01;
  localparam logic [1:0] PC_RB     = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction class plus the ALU function,
// B-operand source and writeback address used by register-register ops.
module ctrl_decode
  import risc_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output instr_cls_t cls,
  output logic [2:0] exec_f,
  output logic [1:0] exec_srcb,
  output logic [1:0] alu_wa
);

  always_comb begin
    cls       = CLS_ILLEGAL;
    exec_f    = ALU_ADDR;
    exec_srcb = SRCB_RB;
    alu_wa    = WA_RC;
    case (opcode)
      OP_ADD: begin
        cls    = CLS_ALU;
        exec_f = ALU_ADD;
      end
      OP_ADI: begin
        cls       = CLS_ALU;
        exec_f    = ALU_ADD;
        exec_srcb = SRCB_IMM6;
        alu_wa    = WA_RB;
      end
      OP_NDU: begin
        cls    = CLS_ALU;
        exec_f = ALU_NAND;
      end
      OP_LHI: begin
        cls       = CLS_ALU;
        exec_f    = ALU_PASSB;
        exec_srcb = SRCB_IMM9;
        alu_wa    = WA_RA;
      end
      OP_LW:   cls = CLS_LOAD;
      OP_SW:   cls = CLS_STORE;
      OP_BEQ:  cls = CLS_BRANCH;
      OP_JAL:  cls = CLS_JAL;
      OP_JLR:  cls = CLS_JLR;
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: one state register, all datapath controls decoded
// combinationally from the current state, the latched opcode and handshakes.
module multicycle_ctrl
  import risc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic [1:0] ir_cz,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       mem_re,
  output logic       mem_we,
  output logic       rf_we,
  output logic [2:0] alu_f,
  output logic [1:0] srca_sel,
  output logic [1:0] srcb_sel,
  output logic [1:0] wa_sel,
  output logic [1:0] wd_sel,
  output logic [1:0] pc_sel,
  output logic [3:0] state,
  output logic       illegal
);

  state_t     state_q;
  state_t     state_d;
  instr_cls_t cls;
  logic [2:0] exec_f;
  logic [1:0] exec_srcb;
  logic [1:0] alu_wa;
  logic       cz_unused;

  // The condition field only steers the register file's write suppression;
  // the control sequence is the same for every condition code.
  assign cz_unused = ^ir_cz;

  ctrl_decode u_decode (
    .opcode    (opcode),
    .cls       (cls),
    .exec_f    (exec_f),
    .exec_srcb (exec_srcb),
    .alu_wa    (alu_wa)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d  = state_q;
    pc_we    = 1'b0;
    ir_we    = 1'b0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    rf_we    = 1'b0;
    illegal  = 1'b0;
    alu_f    = ALU_ADDR;
    srca_sel = SRCA_RA;
    srcb_sel = SRCB_RB;
    wa_sel   = WA_RC;
    wd_sel   = WD_ALU;
    pc_sel   = PC_INC;
    // Reset masks every control so nothing is written during the reset cycle.
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_re = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            pc_sel  = PC_INC;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          case (cls)
            CLS_ALU:             state_d = S_EXEC;
            CLS_LOAD, CLS_STORE: state_d = S_MEMADR;
            CLS_BRANCH:          state_d = S_BRANCH;
            CLS_JAL, CLS_JLR:    state_d = S_JUMP;
            default: begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          endcase
        end
        S_EXEC: begin
          alu_f    = exec_f;
          srcb_sel = exec_srcb;
          state_d  = S_ALUWB;
        end
        S_ALUWB: begin
          // ALU function is held so the flags are written with the result.
          alu_f    = exec_f;
          srcb_sel = exec_srcb;
          rf_we    = 1'b1;
          wa_sel   = alu_wa;
          wd_sel   = WD_ALU;
          state_d  = S_FETCH;
        end
        S_MEMADR: begin
          srca_sel = SRCA_RB;
          srcb_sel = SRCB_IMM6;
          state_d  = (cls == CLS_STORE) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          srca_sel = SRCA_RB;
          srcb_sel = SRCB_IMM6;
          mem_re   = 1'b1;
          if (mem_ready) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          rf_we   = 1'b1;
          wa_sel  = WA_RA;
          wd_sel  = WD_MEM;
          state_d = S_FETCH;
        end
        S_MEMWR: begin
          srca_sel = SRCA_RB;
          srcb_sel = SRCB_IMM6;
          mem_we   = 1'b1;
          if (mem_ready) state_d = S_FETCH;
        end
        S_BRANCH: begin
          alu_f  = ALU_SUB;
          pc_sel = PC_IMM;
          if (alu_zero) pc_we = 1'b1;
          state_d = S_FETCH;
        end
        S_JUMP: begin
          rf_we   = 1'b1;
          wa_sel  = WA_RA;
          wd_sel  = WD_PC;
          pc_we   = 1'b1;
          pc_sel  = (cls == CLS_JLR) ? PC_RB : PC_IMM;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule
